// File: rtl/rv_fetch_pkg.sv
// Shared widths, PC increments and the compressed-instruction test for the fetch front end.
package rv_fetch_pkg;

    localparam int HW_W   = 16;
    localparam int WORD_W = 32;

    localparam logic [2:0] CONST2 = 3'd2;
    localparam logic [2:0] CONST4 = 3'd4;

    // A halfword starts a compressed instruction unless its two low bits are both set.
    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return (hw & 16'h0003) != 16'h0003;
    endfunction

endpackage

// File: rtl/hw_fifo.sv
// Halfword circular queue: up to two pushes and two pops per cycle, two-entry head window.
module hw_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [1:0]                   push_num_i,
    input  logic [HW_W-1:0]              push_hw0_i,
    input  logic [HW_W-1:0]              push_hw1_i,
    input  logic [1:0]                   pop_num_i,
    output logic [HW_W-1:0]              head0_o,
    output logic [HW_W-1:0]              head1_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

    logic [HW_W-1:0]  store_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr, input logic [1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, ptr} + (PTR_W+1)'(n);
        if (s >= DEPTH_P) begin
            s = s - DEPTH_P;
        end
        return s[PTR_W-1:0];
    endfunction

    // Next pointer/count values; a flush empties the queue regardless of push/pop.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            rd_d  = ptr_add(rd_q, pop_num_i);
            wr_d  = ptr_add(wr_q, push_num_i);
            cnt_d = cnt_q + CNT_W'(push_num_i) - CNT_W'(pop_num_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Halfword storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (!flush_i && push_num_i != 2'd0) begin
            store_q[wr_q] <= push_hw0_i;
        end
        if (!flush_i && push_num_i == 2'd2) begin
            store_q[ptr_add(wr_q, 2'd1)] <= push_hw1_i;
        end
    end

    assign head0_o = store_q[rd_q];
    assign head1_o = store_q[ptr_add(rd_q, 2'd1)];
    assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_align_buffer.sv
// Fetch front end: word reads under req/gnt/rvalid, halfword queue, aligned instruction output.
module ifetch_align_buffer
    import rv_fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              DEPTH_HW = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr_out,
    output logic [PC_W-1:0]   instr_pc,
    output logic              instr_compressed
);

    localparam int CNT_W = $clog2(DEPTH_HW+1);

    logic              mem_req_q, mem_req_d;
    logic [PC_W-1:0]   mem_addr_q, mem_addr_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              outstanding_q, outstanding_d;
    logic              discard_q, discard_d;
    logic              skip_low_q, skip_low_d;
    logic              redir_pend_q, redir_pend_d;
    logic [PC_W-1:0]   redir_addr_q, redir_addr_d;

    logic [HW_W-1:0]   head0, head1;
    logic [CNT_W-1:0]  count;
    logic [1:0]        push_num, pop_num;
    logic [HW_W-1:0]   push_hw0, push_hw1;
    logic              head_comp, have_instr, fire, resp_ok;

    hw_fifo #(
        .DEPTH (DEPTH_HW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid),
        .push_num_i (push_num),
        .push_hw0_i (push_hw0),
        .push_hw1_i (push_hw1),
        .pop_num_i  (pop_num),
        .head0_o    (head0),
        .head1_o    (head1),
        .count_o    (count)
    );

    // Decode the queue head and decide how many halfwords to push and pop this cycle.
    always_comb begin
        head_comp  = is_compressed(head0);
        have_instr = (count >= CNT_W'(2)) || ((count >= CNT_W'(1)) && head_comp);
        instr_valid      = !redirect_valid && have_instr;
        instr_out        = head_comp ? {16'h0000, head0} : {head1, head0};
        instr_compressed = head_comp;
        fire    = instr_valid && instr_ready;
        pop_num = fire ? (head_comp ? 2'd1 : 2'd2) : 2'd0;

        resp_ok  = mem_rvalid && outstanding_q;
        push_num = 2'd0;
        push_hw0 = mem_rdata[15:0];
        push_hw1 = mem_rdata[31:16];
        if (resp_ok && !redirect_valid && !discard_q) begin
            if (skip_low_q) begin
                push_num = 2'd1;
                push_hw0 = mem_rdata[31:16];
            end else begin
                push_num = 2'd2;
            end
        end
    end

    // Request, redirect and response bookkeeping; a redirect overrides everything else.
    always_comb begin
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        skip_low_d    = skip_low_q;
        redir_pend_d  = redir_pend_q;
        redir_addr_d  = redir_addr_q;

        if (mem_req_q) begin
            mem_req_d = !mem_gnt;
        end else begin
            mem_req_d = !outstanding_q &&
                        (({1'b0, count} + (CNT_W+1)'(2)) <= (CNT_W+1)'(DEPTH_HW));
        end

        if (mem_req_q && mem_gnt) begin
            outstanding_d = 1'b1;
        end else if (resp_ok) begin
            outstanding_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_d       = redirect_pc & ~PC_W'(1);
            skip_low_d = redirect_pc[1];
            discard_d  = (outstanding_q && !mem_rvalid) || mem_req_q;
            if (mem_req_q && !mem_gnt) begin
                redir_pend_d = 1'b1;
                redir_addr_d = redirect_pc & ~PC_W'(3);
            end else begin
                redir_pend_d = 1'b0;
                mem_addr_d   = redirect_pc & ~PC_W'(3);
            end
        end else begin
            if (fire) begin
                pc_d = pc_q + (head_comp ? PC_W'(CONST2) : PC_W'(CONST4));
            end
            if (resp_ok) begin
                discard_d = 1'b0;
                if (!discard_q) begin
                    skip_low_d = 1'b0;
                end
            end
            if (mem_req_q && mem_gnt) begin
                mem_addr_d   = redir_pend_q ? redir_addr_q : mem_addr_q + PC_W'(CONST4);
                redir_pend_d = 1'b0;
            end
        end
    end

    // Control state registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_PC & ~PC_W'(3);
            pc_q          <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            skip_low_q    <= RESET_PC[1];
            redir_pend_q  <= 1'b0;
            redir_addr_q  <= '0;
        end else begin
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            skip_low_q    <= skip_low_d;
            redir_pend_q  <= redir_pend_d;
            redir_addr_q  <= redir_addr_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign instr_pc = pc_q;

endmodule

// File: tb/tb_ifetch_align_buffer.sv
// Scoreboard bench for ifetch_align_buffer: memory model, expected-instruction queue, redirects and reset.
module tb_ifetch_align_buffer;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_compressed;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pc;
        logic        comp;
    } exp_t;

    exp_t        sbQ[$];
    logic [7:0]  gntLog[$];
    logic [15:0] hwMem [0:127];

    int          total = 0;
    int          bad   = 0;
    int          latency = 1;
    logic        readyVar = 1'b0;
    logic        redirVar = 1'b0;
    logic [7:0]  redirPcVar = 8'h00;
    logic        respPending = 1'b0;
    logic [7:0]  respAddr = 8'h00;
    int          respCnt = 0;
    logic        gntSeen = 1'b0;
    logic [7:0]  lastGntAddr = 8'h00;

    ifetch_align_buffer #(
        .PC_W     (8),
        .DEPTH_HW (4),
        .RESET_PC (8'h00)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_out        (instr_out),
        .instr_pc         (instr_pc),
        .instr_compressed (instr_compressed)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setWord(input logic [7:0] a, input logic [31:0] w);
        logic [6:0] idx;
        idx = a[7:1];
        hwMem[idx]        = w[15:0];
        hwMem[idx + 7'd1] = w[31:16];
    endtask

    function automatic logic [15:0] readHw(input logic [7:0] a);
        return hwMem[a[7:1]];
    endfunction

    // Reference decoder: walk the memory image from startPc and queue n expected instructions.
    task automatic pushStream(input logic [7:0] startPc, input int n);
        logic [7:0]  pc;
        logic [15:0] hw0, hw1;
        exp_t        e;
        pc = startPc;
        for (int i = 0; i < n; i++) begin
            hw0 = readHw(pc);
            if (hw0[1:0] != 2'b11) begin
                e.instr = {16'h0000, hw0};
                e.pc    = pc;
                e.comp  = 1'b1;
                pc      = pc + 8'd2;
            end else begin
                hw1     = readHw(pc + 8'd2);
                e.instr = {hw1, hw0};
                e.pc    = pc;
                e.comp  = 1'b0;
                pc      = pc + 8'd4;
            end
            sbQ.push_back(e);
        end
    endtask

    // One clock: drive inputs and memory model at negedge, then score any handshake.
    task automatic runCycle();
        exp_t e;
        @(negedge clk);
        mem_rvalid = 1'b0;
        if (respPending) begin
            if (respCnt == 0) begin
                mem_rvalid  = 1'b1;
                mem_rdata   = {hwMem[respAddr[7:1] + 7'd1], hwMem[respAddr[7:1]]};
                respPending = 1'b0;
            end else begin
                respCnt--;
            end
        end
        instr_ready    = readyVar;
        redirect_valid = redirVar;
        redirect_pc    = redirPcVar;
        mem_gnt        = mem_req && !respPending;
        #1;
        gntSeen = mem_req && mem_gnt;
        if (gntSeen) begin
            lastGntAddr = mem_addr;
            gntLog.push_back(mem_addr);
            respPending = 1'b1;
            respAddr    = mem_addr;
            respCnt     = latency - 1;
        end
        if (instr_valid && instr_ready) begin
            if (sbQ.size() == 0) begin
                checkOutput("sbDepth", 32'(sbQ.size()), 32'd1);
            end else begin
                e = sbQ.pop_front();
                checkOutput("instrOut", instr_out, e.instr);
                checkOutput("instrPc", {24'h0, instr_pc}, {24'h0, e.pc});
                checkOutput("instrComp", {31'h0, instr_compressed}, {31'h0, e.comp});
            end
        end
    endtask

    task automatic doRedirect(input logic [7:0] pc, input int n);
        redirVar   = 1'b1;
        redirPcVar = pc;
        sbQ.delete();
        pushStream(pc & 8'hFE, n);
        runCycle();
        checkOutput("redirValidOff", {31'h0, instr_valid}, 32'd0);
        redirVar = 1'b0;
    endtask

    task automatic drainStream();
        int budget;
        budget   = 300;
        readyVar = 1'b1;
        while (sbQ.size() > 0 && budget > 0) begin
            runCycle();
            budget--;
        end
        checkOutput("drainLeft", 32'(sbQ.size()), 32'd0);
        readyVar = 1'b0;
    endtask

    task automatic applyStimulus();
        int         found;
        int         gntIdx;
        int         gntBefore;

        // Reset state
        rst = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        runCycle();
        runCycle();
        checkOutput("rstMemReq", {31'h0, mem_req}, 32'd0);
        checkOutput("rstMemAddr", {24'h0, mem_addr}, 32'h00);
        checkOutput("rstInstrPc", {24'h0, instr_pc}, 32'h00);
        checkOutput("rstInstrValid", {31'h0, instr_valid}, 32'd0);
        rst = 1'b1;

        // Sequential 32-bit stream with 1-cycle memory
        latency = 1;
        pushStream(8'h00, 4);
        drainStream();
        checkOutput("gntAddr0", {24'h0, gntLog[0]}, 32'h00);
        checkOutput("gntAddr1", {24'h0, gntLog[1]}, 32'h04);
        checkOutput("gntAddr2", {24'h0, gntLog[2]}, 32'h08);

        // Compressed followed by a word-spanning 32-bit instruction, slower memory
        latency = 3;
        doRedirect(8'h80, 5);
        drainStream();

        // Backpressure: queue fills and requests stop
        latency = 1;
        doRedirect(8'h10, 8);
        for (int i = 0; i < 8; i++) runCycle();
        gntBefore = gntLog.size();
        for (int i = 0; i < 6; i++) runCycle();
        checkOutput("bpMemReq", {31'h0, mem_req}, 32'd0);
        checkOutput("bpNoGnt", 32'(gntLog.size()), 32'(gntBefore));
        checkOutput("bpValid", {31'h0, instr_valid}, 32'd1);
        drainStream();

        // Redirect while the 0x08 response is still in flight
        latency = 4;
        doRedirect(8'h00, 16);
        readyVar = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            runCycle();
            if (gntSeen && lastGntAddr == 8'h08) found = 1;
        end
        checkOutput("waitGnt08", 32'(found), 32'd1);
        gntIdx = gntLog.size();
        doRedirect(8'h40, 4);
        runCycle();
        checkOutput("redirMemAddr", {24'h0, mem_addr}, 32'h40);
        drainStream();
        if (gntLog.size() > gntIdx) begin
            checkOutput("redirFirstGnt", {24'h0, gntLog[gntIdx]}, 32'h40);
        end else begin
            checkOutput("redirGntCount", 32'(gntLog.size()), 32'(gntIdx + 1));
        end

        // Back-to-back redirects, last one to an odd halfword
        latency = 2;
        doRedirect(8'h80, 2);
        doRedirect(8'h42, 3);
        drainStream();

        // Asynchronous reset between gnt and rvalid
        latency = 4;
        doRedirect(8'h00, 0);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            runCycle();
            if (gntSeen && lastGntAddr == 8'h04) found = 1;
        end
        checkOutput("waitGnt04", 32'(found), 32'd1);
        runCycle();
        rst = 1'b0;
        #1;
        checkOutput("midRstMemReq", {31'h0, mem_req}, 32'd0);
        checkOutput("midRstValid", {31'h0, instr_valid}, 32'd0);
        checkOutput("midRstMemAddr", {24'h0, mem_addr}, 32'h00);
        checkOutput("midRstInstrPc", {24'h0, instr_pc}, 32'h00);
        sbQ.delete();
        runCycle();
        runCycle();
        rst = 1'b1;
        pushStream(8'h00, 4);
        drainStream();
    endtask

    // Build the memory image, run every scenario, then report.
    initial begin
        for (int a = 0; a < 256; a += 4) begin
            setWord(8'(a), 32'h00000013 | (32'(a) << 20));
        end
        setWord(8'h00, 32'h00500093);
        setWord(8'h04, 32'h00100113);
        setWord(8'h08, 32'h00200193);
        setWord(8'h40, 32'h45050001);
        setWord(8'h44, 32'h00a00593);
        setWord(8'h80, 32'h00934505);
        setWord(8'h84, 32'h01130050);
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
